// File: rtl/wave_mult_arb.sv
// Round-robin sequencer sharing one registered DW x DW multiplier between NREQ requesters.
// Define WAVE_MULT_ARB_FIXPRIO_EN for fixed lowest-index-wins priority instead of round robin.
module wave_mult_arb #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREQ = 2,
  parameter int unsigned MLAT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   opa,
  input  logic [NREQ*DW-1:0]   opb,
  output logic [NREQ-1:0]      gnt,
  output logic                 mul_en,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_b,
  input  logic [2*DW-1:0]      mul_y,
  output logic [2*DW-1:0]      res,
  output logic [NREQ-1:0]      res_vld,
  output logic                 busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MLAT + 1);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q;
  logic [IW-1:0]        owner_q;
  logic [CW-1:0]        cnt_q;
  logic [NREQ-1:0]      gnt_q;
  logic                 mul_en_q;
  logic [DW-1:0]        mul_a_q;
  logic [DW-1:0]        mul_b_q;
  logic [2*DW-1:0]      res_q;
  logic [NREQ-1:0]      res_vld_q;
  logic                 busy_q;

  logic [IW-1:0]        base;
  logic [NREQ-1:0]      rot;
  logic                 win_vld;
  logic [IW:0]          win_sum;
  logic [IW-1:0]        win_idx;
  logic [NREQ-1:0]      win_oh;
  logic [NREQ-1:0]      owner_oh;
  logic [DW-1:0]        win_a;
  logic [DW-1:0]        win_b;

`ifdef WAVE_MULT_ARB_FIXPRIO_EN
  assign base = '0;
  assign rot  = req;
`else
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;

  // Rotate so that bit 0 of rot is the requester at ptr; search then runs upward with wrap.
  assign base  = ptr_q;
  assign rot   = NREQ'({req, req} >> ptr_q);
  assign ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif

  always_comb begin
    win_vld = 1'b0;
    win_sum = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_vld && rot[i]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, base} + (IW+1)'(i);
      end
    end
    win_idx = (win_sum >= NREQ_W) ? IW'(win_sum - NREQ_W) : IW'(win_sum);
  end

  assign win_oh   = NREQ'(1) << win_idx;
  assign owner_oh = NREQ'(1) << owner_q;
  assign win_a    = DW'(opa >> (win_idx * DW));
  assign win_b    = DW'(opb >> (win_idx * DW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      mul_en_q  <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      res_q     <= '0;
      res_vld_q <= '0;
      busy_q    <= 1'b0;
`ifndef WAVE_MULT_ARB_FIXPRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      gnt_q     <= '0;
      mul_en_q  <= 1'b0;
      res_vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (enable && win_vld) begin
            owner_q  <= win_idx;
            mul_a_q  <= win_a;
            mul_b_q  <= win_b;
            gnt_q    <= win_oh;
            mul_en_q <= 1'b1;
            cnt_q    <= CW'(MLAT);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            res_q     <= mul_y;
            res_vld_q <= owner_oh;
`ifndef WAVE_MULT_ARB_FIXPRIO_EN
            ptr_q     <= ptr_d;
`endif
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign mul_en  = mul_en_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign res     = res_q;
  assign res_vld = res_vld_q;
  assign busy    = busy_q;

endmodule
